// File: rtl/vga_sync_rx.sv
// vga_sync_rx -- VGA timing receiver.
// Synchronizes asynchronous hsync/vsync/colour inputs. Measures line length,
// hsync width and frame height, then locks onto the incoming timing. Once
// locked it emits active-area pixel coordinates and colour.
//
// Ports:
//   clk, reset            system clock; asynchronous active-low reset
//   pix_en                one-cycle strobe per pixel period
//   vga_h_sync/vga_v_sync active-low syncs, asynchronous to clk
//   vga_R/G/B             colour bits, asynchronous to clk
//   locked                timing locked (state LOCKED)
//   h_total/v_total       measured pixels per line / lines per frame
//   h_sync_w              measured hsync width in pixels
//   pix_x/pix_y/pix_rgb   registered active-area column, row and colour
//   pix_valid             qualifies pix_x/pix_y/pix_rgb
//   frame_start           one-cycle pulse when a new frame begins
//   err                   one-cycle pulse on a timing fault
module vga_sync_rx #(
    parameter int unsigned H_ACT_START = 48,
    parameter int unsigned H_ACT_LEN   = 640,
    parameter int unsigned V_ACT_START = 2,
    parameter int unsigned V_ACT_LEN   = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       vga_h_sync,
    input  logic       vga_v_sync,
    input  logic       vga_R,
    input  logic       vga_G,
    input  logic       vga_B,
    output logic       locked,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic [9:0] h_sync_w,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic [2:0] pix_rgb,
    output logic       frame_start,
    output logic       err
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [10:0] HA_LO = 11'(H_ACT_START);
    localparam logic [10:0] HA_HI = 11'(H_ACT_START + H_ACT_LEN);
    localparam logic [10:0] VA_LO = 11'(V_ACT_START);
    localparam logic [10:0] VA_HI = 11'(V_ACT_START + V_ACT_LEN);
    localparam logic [9:0]  HCNT_PRE_SAT = 10'd1022;

    // synchronizer stages
    logic       hs_meta_q, hs_q, vs_meta_q, vs_q;
    logic [2:0] rgb_meta_q, rgb_q;

    // timing state
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       pend_q, pend_d;
    logic [9:0] hw_meas_q, hw_meas_d;
    state_t     state_q, state_d;
    logic       need_store_q, need_store_d;
    logic       mism_q, mism_d;
    logic       full_q, full_d;

    // output registers
    logic [9:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [9:0] h_sync_w_q, h_sync_w_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic       pix_valid_q, pix_valid_d;
    logic [2:0] pix_rgb_q, pix_rgb_d;
    logic       frame_q, frame_d, err_q, err_d;

    // combinational helpers
    logic        hs_fall, hs_rise, vs_fall, frame_evt, sat_hit, len_ok;
    logic [10:0] line_len, frame_len;

    // Syncs park at 1 (idle) during reset so a low level present at release
    // is seen as a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_meta_q  <= 1'b1;
            hs_q       <= 1'b1;
            vs_meta_q  <= 1'b1;
            vs_q       <= 1'b1;
            rgb_meta_q <= '0;
            rgb_q      <= '0;
        end else begin
            hs_meta_q  <= vga_h_sync;
            hs_q       <= hs_meta_q;
            vs_meta_q  <= vga_v_sync;
            vs_q       <= vs_meta_q;
            rgb_meta_q <= {vga_R, vga_G, vga_B};
            rgb_q      <= rgb_meta_q;
        end
    end

    always_comb begin
        hs_fall   = pix_en & hs_prev_q & ~hs_q;
        hs_rise   = pix_en & ~hs_prev_q & hs_q;
        vs_fall   = pix_en & vs_prev_q & ~vs_q;
        frame_evt = hs_fall & pend_q;
        line_len  = {1'b0, hcnt_q} + 11'd1;
        frame_len = {1'b0, vcnt_q} + 11'd1;
        len_ok    = (line_len == {1'b0, h_total_q});
        sat_hit   = pix_en & ~hs_fall & (hcnt_q == HCNT_PRE_SAT);

        hs_prev_d = pix_en ? hs_q : hs_prev_q;
        vs_prev_d = pix_en ? vs_q : vs_prev_q;

        hcnt_d = hcnt_q;
        if (hs_fall) begin
            hcnt_d = '0;
        end else if (pix_en && (hcnt_q != '1)) begin
            hcnt_d = hcnt_q + 10'd1;
        end

        vcnt_d = vcnt_q;
        if (frame_evt) begin
            vcnt_d = '0;
        end else if (hs_fall && (vcnt_q != '1)) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        // A vsync coinciding with the frame-starting hsync re-arms the flag,
        // so the next frame begins at the following hsync.
        pend_d = pend_q;
        if (frame_evt) begin
            pend_d = 1'b0;
        end
        if (vs_fall) begin
            pend_d = 1'b1;
        end

        // width = number of low samples, including the falling-edge sample
        hw_meas_d = hs_rise ? hcnt_d : hw_meas_q;

        state_d      = state_q;
        need_store_d = need_store_q;
        mism_d       = mism_q;
        full_d       = full_q;
        h_total_d    = h_total_q;
        h_sync_w_d   = h_sync_w_q;
        v_total_d    = v_total_q;
        err_d        = 1'b0;

        case (state_q)
            SEARCH: begin
                if (frame_evt) begin
                    state_d      = MEASURE;
                    need_store_d = 1'b1;
                    mism_d       = 1'b0;
                    full_d       = 1'b1;
                end
            end
            MEASURE: begin
                // full_q: measurement began at a frame start, so vcnt covers a
                // whole frame; entry from a mid-frame fault needs one more frame.
                if (frame_evt) begin
                    if (full_q && !need_store_q && !mism_q && len_ok && !frame_len[10]) begin
                        state_d   = LOCKED;
                        v_total_d = frame_len[9:0];
                    end else begin
                        need_store_d = 1'b1;
                        mism_d       = 1'b0;
                        full_d       = 1'b1;
                    end
                end else if (hs_fall) begin
                    if (need_store_q) begin
                        h_total_d    = line_len[9:0];
                        h_sync_w_d   = hw_meas_q;
                        need_store_d = 1'b0;
                        mism_d       = 1'b0;
                    end else if (!len_ok) begin
                        mism_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (hs_fall) begin
                    if (!len_ok || (frame_evt && (frame_len != {1'b0, v_total_q}))) begin
                        err_d        = 1'b1;
                        state_d      = MEASURE;
                        need_store_d = 1'b1;
                        mism_d       = 1'b0;
                        full_d       = frame_evt;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        // runaway line: fires once, on the step into saturation
        if (sat_hit) begin
            err_d   = 1'b1;
            state_d = SEARCH;
        end

        frame_d = frame_evt;

        pix_valid_d = pix_en && (state_d == LOCKED)
                   && ({1'b0, hcnt_d} >= HA_LO) && ({1'b0, hcnt_d} < HA_HI)
                   && ({1'b0, vcnt_d} >= VA_LO) && ({1'b0, vcnt_d} < VA_HI);
        pix_x_d   = pix_valid_d ? (hcnt_d - HA_LO[9:0]) : pix_x_q;
        pix_y_d   = pix_valid_d ? (vcnt_d - VA_LO[9:0]) : pix_y_q;
        pix_rgb_d = pix_valid_d ? rgb_q : pix_rgb_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            pend_q       <= 1'b0;
            hw_meas_q    <= '0;
            state_q      <= SEARCH;
            need_store_q <= 1'b0;
            mism_q       <= 1'b0;
            full_q       <= 1'b0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            h_sync_w_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_rgb_q    <= '0;
            frame_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            pend_q       <= pend_d;
            hw_meas_q    <= hw_meas_d;
            state_q      <= state_d;
            need_store_q <= need_store_d;
            mism_q       <= mism_d;
            full_q       <= full_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            h_sync_w_q   <= h_sync_w_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_valid_q  <= pix_valid_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_q      <= frame_d;
            err_q        <= err_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign h_sync_w    = h_sync_w_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a scaled-down raster (40-pixel lines,
// 5-pixel hsync, 12-line frames, 24x8 active area) so the run stays short.
module tb_vga_sync_rx;

    localparam int unsigned HAS  = 8;
    localparam int unsigned HAL  = 24;
    localparam int unsigned VAS  = 2;
    localparam int unsigned VAL  = 8;
    localparam int unsigned LLEN = 40;
    localparam int unsigned HSW  = 5;
    localparam int unsigned NLIN = 12;
    localparam int unsigned NONE = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_en = 1'b0;
    logic       vga_h_sync = 1'b1;
    logic       vga_v_sync = 1'b1;
    logic       vga_R = 1'b0;
    logic       vga_G = 1'b0;
    logic       vga_B = 1'b0;
    logic       locked;
    logic [9:0] h_total, v_total, h_sync_w, pix_x, pix_y;
    logic       pix_valid;
    logic [2:0] pix_rgb;
    logic       frame_start;
    logic       err;

    vga_sync_rx #(
        .H_ACT_START(HAS),
        .H_ACT_LEN  (HAL),
        .V_ACT_START(VAS),
        .V_ACT_LEN  (VAL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .vga_h_sync (vga_h_sync),
        .vga_v_sync (vga_v_sync),
        .vga_R      (vga_R),
        .vga_G      (vga_G),
        .vga_B      (vga_B),
        .locked     (locked),
        .h_total    (h_total),
        .v_total    (v_total),
        .h_sync_w   (h_sync_w),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .frame_start(frame_start),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned cur_x = 0;
    int unsigned cur_li = 0;

    // monitor state
    int unsigned fs_total = 0, fs_line = 0, err_total = 0, err_x = 0;
    int unsigned pv_total = 0, pv_frame = 0, bad_frame = 0, pv_unlocked = 0;
    int unsigned ex = 0, ey = 0;
    int unsigned first_x = 0, first_y = 0, last_x = 0, last_y = 0;
    logic        first_seen = 1'b0;
    int unsigned pv_snap = 0;

    function automatic logic [2:0] pat(input int unsigned x, input int unsigned l);
        int unsigned t;
        t = x * 5 + (x >> 2) + l * 3;
        return t[2:0];
    endfunction

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // pixel driven as (x, l) is sampled with hcnt=x, vcnt=l of the frame
    task automatic px(input logic h, input logic v, input int unsigned x, input int unsigned l);
        @(negedge clk);
        cur_x = x;
        cur_li = l;
        vga_h_sync = h;
        vga_v_sync = v;
        {vga_R, vga_G, vga_B} = pat(x, l);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic line(input int unsigned l, input int unsigned len);
        for (int unsigned x = 0; x < len; x++) begin
            px(x >= HSW, l != NLIN - 1, x, l);
        end
    endtask

    task automatic frame(input int unsigned short_l);
        for (int unsigned l = 0; l < NLIN; l++) begin
            line(l, (l == short_l) ? LLEN - 1 : LLEN);
        end
    endtask

    task automatic reset_chk(input string w);
        chk({w, ".locked"},      32'(locked), 0);
        chk({w, ".h_total"},     32'(h_total), 0);
        chk({w, ".v_total"},     32'(v_total), 0);
        chk({w, ".h_sync_w"},    32'(h_sync_w), 0);
        chk({w, ".pix_x"},       32'(pix_x), 0);
        chk({w, ".pix_y"},       32'(pix_y), 0);
        chk({w, ".pix_valid"},   32'(pix_valid), 0);
        chk({w, ".pix_rgb"},     32'(pix_rgb), 0);
        chk({w, ".frame_start"}, 32'(frame_start), 0);
        chk({w, ".err"},         32'(err), 0);
    endtask

    task automatic locked_frame_chk(input string w);
        chk({w, ".locked"},  32'(locked), 1);
        chk({w, ".pv_cnt"},  pv_frame, HAL * VAL);
        chk({w, ".raster"},  bad_frame, 0);
        chk({w, ".first_x"}, first_x, 0);
        chk({w, ".first_y"}, first_y, 0);
        chk({w, ".last_x"},  last_x, HAL - 1);
        chk({w, ".last_y"},  last_y, VAL - 1);
    endtask

    // Raster model: expects pixels in row-major order from (0,0) each frame,
    // with colour equal to what was driven at hcnt=x+HAS, vcnt=y+VAS.
    always @(negedge clk) begin
        if (frame_start) begin
            fs_total   <= fs_total + 1;
            fs_line    <= cur_li;
            ex         <= 0;
            ey         <= 0;
            pv_frame   <= 0;
            bad_frame  <= 0;
            first_seen <= 1'b0;
        end
        if (err) begin
            err_total <= err_total + 1;
            err_x     <= cur_x;
        end
        if (pix_valid) begin
            pv_total <= pv_total + 1;
            pv_frame <= pv_frame + 1;
            if (!locked) pv_unlocked <= pv_unlocked + 1;
            if (!first_seen) begin
                first_x    <= 32'(pix_x);
                first_y    <= 32'(pix_y);
                first_seen <= 1'b1;
            end
            last_x <= 32'(pix_x);
            last_y <= 32'(pix_y);
            if (pix_x !== 10'(ex) || pix_y !== 10'(ey) || pix_rgb !== pat(ex + HAS, ey + VAS))
                bad_frame <= bad_frame + 1;
            if (ex == HAL - 1) begin
                ex <= 0;
                ey <= ey + 1;
            end else begin
                ex <= ex + 1;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_chk("init");
        reset = 1'b1;
        for (int unsigned i = 0; i < 4; i++) px(1'b1, 1'b1, 30 + i, NLIN - 2);
        line(NLIN - 1, LLEN);   // vsync line preceding frame 1

        // frame 1: SEARCH -> MEASURE; vsync fell with hsync, frame starts next line
        frame(NONE);
        chk("f1.fs_cnt", fs_total, 1);
        chk("f1.fs_line", fs_line, 0);
        chk("f1.locked", 32'(locked), 0);
        chk("f1.h_total", 32'(h_total), LLEN);
        chk("f1.h_sync_w", 32'(h_sync_w), HSW);

        // frame 2: locked, full active area
        frame(NONE);
        chk("f2.fs_cnt", fs_total, 2);
        chk("f2.fs_line", fs_line, 0);
        chk("f2.v_total", 32'(v_total), NLIN);
        chk("f2.err_cnt", err_total, 0);
        locked_frame_chk("f2");

        // frame 3: line 5 one pixel short
        for (int unsigned l = 0; l < 7; l++) line(l, (l == 5) ? LLEN - 1 : LLEN);
        chk("short.err_cnt", err_total, 1);
        chk("short.locked", 32'(locked), 0);
        for (int unsigned l = 7; l < NLIN; l++) line(l, LLEN);
        frame(NONE);
        frame(NONE);
        chk("relock.err_cnt", err_total, 1);
        locked_frame_chk("relock");

        // frame 6: line 3 with hsync held high to 1100 pixels
        for (int unsigned l = 0; l < 4; l++) line(l, (l == 3) ? 1100 : LLEN);
        chk("long.err_cnt", err_total, 2);
        chk("long.err_x", err_x, 1024);
        chk("long.locked", 32'(locked), 0);
        pv_snap = pv_total;
        for (int unsigned l = 4; l < NLIN; l++) line(l, LLEN);
        frame(NONE);
        chk("long.no_pv", pv_total - pv_snap, 0);
        chk("long.locked2", 32'(locked), 0);
        frame(NONE);
        chk("long.err_cnt2", err_total, 2);
        locked_frame_chk("long.relock");

        // frame 9: reset asserted mid active line
        for (int unsigned l = 0; l < 4; l++) line(l, LLEN);
        for (int unsigned x = 0; x < 13; x++) px(x >= HSW, 1'b1, x, 4);
        chk("mid.pv_before", 32'(pix_valid), 1);
        #1 reset = 1'b0;
        #1 reset_chk("mid");
        for (int unsigned x = 13; x < LLEN; x++) begin
            if (x == 16) reset = 1'b1;
            px(x >= HSW, 1'b1, x, 4);
        end
        for (int unsigned l = 5; l < NLIN; l++) line(l, LLEN);
        frame(NONE);
        chk("rst.locked_early", 32'(locked), 0);
        frame(NONE);
        chk("rst.h_total", 32'(h_total), LLEN);
        chk("rst.h_sync_w", 32'(h_sync_w), HSW);
        chk("rst.v_total", 32'(v_total), NLIN);
        locked_frame_chk("rst.relock");

        chk("pv_while_unlocked", pv_unlocked, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
